fetch_sequencer: RTL

//  Parametrised instruction-fetch sequencer replacing the fixed cycle/PC/stack wiring in cpuTop.

---
 rtl/fetch_sequencer_if.sv | 39 +++
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Bundle of ROM, decoder and fetch-status signals around the instruction-fetch sequencer.
// The master side is the sequencer itself; the slave side is ROM/decoder/environment.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              stall;
  logic [3:0]        romNibble;
  logic              twoWord;
  logic              jmpReq;
  logic              callReq;
  logic              retReq;
  logic [ADDR_W-1:0] jmpAddr;
  logic [2:0]        cycle;
  logic              sync;
  logic [3:0]        addrNibble;
  logic [ADDR_W-1:0] pcAddr;
  logic [3:0]        opr;
  logic [3:0]        opa;
  logic [3:0]        oprB;
  logic [3:0]        opaB;
  logic              instrValid;
  logic              operandValid;
  logic              secondWord;
  logic [2:0]        sp;
  logic              stackOverflow;
  logic              stackUnderflow;

  modport master (
    input  stall, romNibble, twoWord, jmpReq, callReq, retReq, jmpAddr,
    output cycle, sync, addrNibble, pcAddr, opr, opa, oprB, opaB,
           instrValid, operandValid, secondWord, sp, stackOverflow, stackUnderflow
  );

  modport slave (
    output stall, romNibble, twoWord, jmpReq, callReq, retReq, jmpAddr,
    input  cycle, sync, addrNibble, pcAddr, opr, opa, oprB, opaB,
           instrValid, operandValid, secondWord, sp, stackOverflow, stackUnderflow
  );
endinterface

// File: rtl/fetch_sequencer.sv
// 8-phase instruction-fetch sequencer: PC nibble output, opcode latching, two-word
// instructions, jump/call/return with a circular return stack and sticky fault flags.
module fetch_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X3 = 3'd7;
  localparam logic [2:0] DEPTH = 3'(STACK_DEPTH);

  logic [2:0]        cycle_q;
  logic [ADDR_W-1:0] pc_q;
  logic [3:0]        opr_q, opa_q, oprb_q, opab_q;
  logic              instr_valid_q, operand_valid_q, second_q;
  logic [2:0]        sp_q;
  logic              ovf_q, udf_q;
  logic [ADDR_W-1:0] stack_q [8];

  logic [11:0]       pc_ext;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic [3:0]        addr_nibble;

  assign pc_ext    = 12'(pc_q);
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign stack_top = stack_q[sp_q - 3'd1];

  always_comb begin
    // NOTE: default first so every path assigns addr_nibble and no latch is inferred.
    addr_nibble = 4'h0;
    case (cycle_q)
      PH_A1:   addr_nibble = pc_ext[3:0];
      PH_A2:   addr_nibble = pc_ext[7:4];
      PH_A3:   addr_nibble = pc_ext[11:8];
      default: addr_nibble = 4'h0;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q         <= PH_A1;
      pc_q            <= '0;
      opr_q           <= '0;
      opa_q           <= '0;
      oprb_q          <= '0;
      opab_q          <= '0;
      instr_valid_q   <= 1'b0;
      operand_valid_q <= 1'b0;
      second_q        <= 1'b0;
      sp_q            <= '0;
      ovf_q           <= 1'b0;
      udf_q           <= 1'b0;
      // NOTE: the return stack is a small register file that must come up cleared, so it is reset too.
      for (int i = 0; i < 8; i++) stack_q[3'(i)] <= '0;
    end else if (!bus.stall) begin
      cycle_q         <= cycle_q + 3'd1;
      instr_valid_q   <= (cycle_q == PH_M2) && !second_q;
      operand_valid_q <= (cycle_q == PH_M2) && second_q;

      if (cycle_q == PH_M1) begin
        if (second_q) oprb_q <= bus.romNibble;
        else          opr_q  <= bus.romNibble;
      end
      if (cycle_q == PH_M2) begin
        if (second_q) opab_q <= bus.romNibble;
        else          opa_q  <= bus.romNibble;
      end

      if (cycle_q == PH_X3) begin
        if (!second_q && bus.twoWord) begin
          pc_q     <= pc_inc;
          second_q <= 1'b1;
        end else begin
          second_q <= 1'b0;
          if (bus.retReq) begin
            if (sp_q != 3'd0) begin
              pc_q <= stack_top;
              sp_q <= sp_q - 3'd1;
            end else begin
              pc_q  <= pc_inc;
              udf_q <= 1'b1;
            end
          end else if (bus.callReq) begin
            pc_q <= bus.jmpAddr;
            if (sp_q == DEPTH) begin
              // Full stack: drop the oldest return address and append the new one on top.
              for (int i = 0; i < STACK_DEPTH - 1; i++) stack_q[3'(i)] <= stack_q[3'(i + 1)];
              stack_q[DEPTH - 3'd1] <= pc_inc;
              ovf_q <= 1'b1;
            end else begin
              stack_q[sp_q] <= pc_inc;
              sp_q          <= sp_q + 3'd1;
            end
          end else if (bus.jmpReq) begin
            pc_q <= bus.jmpAddr;
          end else begin
            pc_q <= pc_inc;
          end
        end
      end
    end
  end

  assign bus.cycle          = cycle_q;
  assign bus.sync           = (cycle_q == PH_A1);
  assign bus.addrNibble     = addr_nibble;
  assign bus.pcAddr         = pc_q;
  assign bus.opr            = opr_q;
  assign bus.opa            = opa_q;
  assign bus.oprB           = oprb_q;
  assign bus.opaB           = opab_q;
  assign bus.instrValid     = instr_valid_q;
  assign bus.operandValid   = operand_valid_q;
  assign bus.secondWord     = second_q;
  assign bus.sp             = sp_q;
  assign bus.stackOverflow  = ovf_q;
  assign bus.stackUnderflow = udf_q;

endmodule
